alu_mult_sequencer: RTL

- Multi-cycle unsigned 32x32->64 shift-add multiplier that time-shares the existing 32-bit ALU.
- Sits beside the ALU in the execute path: it drives the ALU operands and command, and consumes the ALU result and carryout.
- Requests and results use valid/ready handshakes.
- Each iteration performs one ALU ADD, so the ALU's adder gets cycle-accurate sequential stimulus.

---
 rtl/alu_mult_sequencer_pkg.sv | 30 +++
 rtl/alu_mult_datapath.sv | 67 ++++++
 rtl/alu_mult_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_mult_sequencer_pkg.sv
// Shared definitions for the ALU-sharing shift-add multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Holds the ALU command codes (same encoding the ALU decodes) and the
// sequencer state encoding.
package alu_mult_sequencer_pkg;

    // ALU command encoding, matching the ALU's decoder.
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_cmd_e;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    localparam int unsigned SEQ_WIDTH = 32;
    localparam int unsigned SEQ_CNT_W = 5;

endpackage

// File: rtl/alu_mult_datapath.sv
// Purpose: partial-product registers, ALU operand gating and per-step shift.
// Latency: one shift-add step per clock while shift is high; product capture is one clock.
// Backpressure: none; the controlling FSM decides when load/shift/capture fire.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   load, shift, capture        step controls from the sequencer FSM
//   multiplicand, multiplier    operands sampled on load
//   alu_result, alu_carryout    33-bit partial sum returned by the ALU
//   alu_operand_a/_b            ALU operand drive
//   product                     registered 64-bit result
module alu_mult_datapath
    import alu_mult_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               shift,
    input  logic               capture,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carryout,
    output logic [WIDTH-1:0]   alu_operand_a,
    output logic [WIDTH-1:0]   alu_operand_b,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [WIDTH-1:0] m_reg;

    // A cleared multiplier bit makes the ALU add zero, so its carryout is 0
    // and P_hi just shifts; no bypass path around the adder is needed.
    always_comb begin
        alu_operand_a = p_hi;
        alu_operand_b = p_lo[0] ? m_reg : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_hi  <= '0;
            p_lo  <= '0;
            m_reg <= '0;
        end else if (load) begin
            m_reg <= multiplicand;
            p_hi  <= '0;
            p_lo  <= multiplier;
        end else if (shift) begin
            // 33-bit sum on top, consumed multiplier bit falls off the bottom.
            {p_hi, p_lo} <= {alu_carryout, alu_result, p_lo[WIDTH-1:1]};
        end
    end

    // Output register decouples the consumer from the working registers,
    // which the next request reloads while this result may still be held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (capture) begin
            product <= {p_hi, p_lo};
        end
    end

endmodule

// File: rtl/alu_mult_sequencer.sv
// Purpose: unsigned 32x32->64 shift-add multiply that borrows the shared ALU adder.
// Latency: out_valid rises 33 clocks after the accepting edge (32 add steps + product capture).
// Backpressure: product/out_valid hold while out_ready is low; in_ready stays low until the result is taken.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           request handshake; multiplicand/multiplier sampled on accept
//   out_valid/out_ready/product result handshake
//   busy                        high while add steps are running
//   alu_operand_a/_b/command    drive to the shared ALU (command fixed at ADD)
//   alu_result/alu_carryout     ALU sum returned in the same cycle
module alu_mult_sequencer
    import alu_mult_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = SEQ_WIDTH,
    parameter logic [2:0]  ADD_CMD = ALU_ADD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic [WIDTH-1:0]   alu_operand_a,
    output logic [WIDTH-1:0]   alu_operand_b,
    output logic [2:0]         alu_command,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carryout
);

    seq_state_e           state_q;
    seq_state_e           state_d;
    logic [SEQ_CNT_W-1:0] count_q;
    logic                 out_valid_q;
    logic                 accept;
    logic                 shift;
    logic                 capture;
    logic                 out_fire;

    // The first DONE cycle captures the product; out_valid follows from it,
    // so the result handshake (and any back-to-back accept) only happens once
    // a product is actually presented.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        shift    = 1'b0;
        capture  = 1'b0;
        out_fire = out_valid_q && out_ready;
        unique case (state_q)
            SEQ_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                shift = 1'b1;
                if (count_q == SEQ_CNT_W'(WIDTH - 1)) begin
                    state_d = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                capture  = !out_valid_q;
                in_ready = out_fire;
                if (out_fire) begin
                    state_d = in_valid ? SEQ_RUN : SEQ_IDLE;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
        accept = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // count wraps from 31 back to 0 on the final add step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= '0;
        end else if (shift) begin
            count_q <= count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign busy        = (state_q == SEQ_RUN);
    assign alu_command = ADD_CMD;

    alu_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (accept),
        .shift         (shift),
        .capture       (capture),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .alu_result    (alu_result),
        .alu_carryout  (alu_carryout),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .product       (product)
    );

endmodule
